// File: rtl/reg_history_pkg.sv
// Shared types for reg_history: the per-cycle history operation and its decode.
package reg_history_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_CLEAR
    } hist_op_t;

    // clear dominates; retain together with undo overwrites the newest entry in place.
    function automatic hist_op_t hist_decode(input logic clear, input logic retain, input logic undo);
        if (clear)                return OP_CLEAR;
        else if (retain && undo)  return OP_REPLACE;
        else if (retain)          return OP_PUSH;
        else if (undo)            return OP_POP;
        else                      return OP_HOLD;
    endfunction

endpackage

// File: rtl/reg_history_if.sv
// Data/control bundle for reg_history. The undo signal exists only when
// REG_HISTORY_UNDO_EN is defined.
interface reg_history_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  valor_entrada;
    logic          retain;
    logic          clear;
`ifdef REG_HISTORY_UNDO_EN
    logic          undo;
`endif
    logic [IW-1:0] rd_idx;
    logic [N-1:0]  valor_salida;
    logic [N-1:0]  rd_valor;
    logic [CW-1:0] count;
    logic          full;

`ifdef REG_HISTORY_UNDO_EN
    modport master (output valor_entrada, retain, clear, undo, rd_idx,
                    input  valor_salida, rd_valor, count, full);
    modport slave  (input  valor_entrada, retain, clear, undo, rd_idx,
                    output valor_salida, rd_valor, count, full);
`else
    modport master (output valor_entrada, retain, clear, rd_idx,
                    input  valor_salida, rd_valor, count, full);
    modport slave  (input  valor_entrada, retain, clear, rd_idx,
                    output valor_salida, rd_valor, count, full);
`endif

endinterface

// File: rtl/reg_history_cell.sv
// One history entry: holds, takes the newer neighbour (push), the older
// neighbour (pop) or zero (clear) according to its per-cell op.
module reg_history_cell
    import reg_history_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  hist_op_t     op,
    input  logic [N-1:0] prev,
    input  logic [N-1:0] next,
    output logic [N-1:0] value
);
    logic [N-1:0] value_q;
    logic [N-1:0] value_d;

    always_comb begin
        value_d = value_q;
        case (op)
            OP_PUSH:  value_d = prev;
            OP_POP:   value_d = next;
            OP_CLEAR: value_d = '0;
            default:  value_d = value_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/reg_history.sv
// N-bit capture register with DEPTH-entry history and registered read port.
// Define REG_HISTORY_UNDO_EN to enable undo (pop) and replace operations.
module reg_history
    import reg_history_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    reg_history_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic          undo_w;
    hist_op_t      op_raw;
    hist_op_t      op;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic [N-1:0]  rd_valor_q, rd_valor_d;
    logic [N-1:0]  entry [DEPTH];

`ifdef REG_HISTORY_UNDO_EN
    assign undo_w = bus.undo;
`else
    assign undo_w = 1'b0;
`endif

    // A pop on an empty history must not underflow count, so it degrades to hold.
    always_comb begin
        op_raw = hist_decode(bus.clear, bus.retain, undo_w);
        op     = op_raw;
        if (op_raw == OP_POP && count_q == '0) op = OP_HOLD;
    end

    always_comb begin
        count_d = count_q;
        case (op)
            OP_CLEAR:   count_d = '0;
            OP_PUSH:    count_d = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
            OP_POP:     count_d = count_q - CW'(1);
            OP_REPLACE: count_d = (count_q == '0) ? CW'(1) : count_q;
            default:    count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    // Read samples pre-update contents; indices at or beyond count read as zero.
    always_comb begin
        rd_valor_d = '0;
        if (op != OP_CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.rd_idx == IW'(i) && CW'(i) < count_q) rd_valor_d = entry[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            rd_valor_q <= '0;
        end else begin
            count_q    <= count_d;
            full_q     <= full_d;
            rd_valor_q <= rd_valor_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
        logic [N-1:0] prev_w;
        logic [N-1:0] next_w;
        hist_op_t     cell_op;

        if (gi == 0) begin : g_head
            assign prev_w = bus.valor_entrada;
        end else begin : g_body
            assign prev_w = entry[gi-1];
        end

        if (gi == DEPTH - 1) begin : g_tail
            assign next_w = '0;
        end else begin : g_inner
            assign next_w = entry[gi+1];
        end

        // Replace only rewrites the newest entry; everything older holds.
        assign cell_op = (op == OP_REPLACE) ? ((gi == 0) ? OP_PUSH : OP_HOLD) : op;

        reg_history_cell #(.N(N)) u_cell (
            .clk   (clk),
            .reset (reset),
            .op    (cell_op),
            .prev  (prev_w),
            .next  (next_w),
            .value (entry[gi])
        );
    end

    assign bus.valor_salida = entry[0];
    assign bus.rd_valor     = rd_valor_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;

endmodule

// File: tb/tb_reg_history.sv
// Self-checking bench for reg_history (N=8, DEPTH=4): directed scenarios plus
// randomized traffic against a queue-based history model.
module tb_reg_history;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    // Model: newest value at the front of the queue.
    logic [N-1:0] mq[$];
    logic [N-1:0] mrd;

    logic [19:0] got;
    logic [19:0] exp_v;

    reg_history_if #(.N(N), .DEPTH(DEPTH)) bus ();

    reg_history #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] model_view();
        logic [N-1:0] top;
        top = (mq.size() > 0) ? mq[0] : '0;
        return {top, 3'(mq.size()), (mq.size() == DEPTH), mrd};
    endfunction

    task automatic cycle(input logic rst, input logic clr, input logic ret, input logic und,
                         input logic [N-1:0] v, input logic [1:0] idx);
        reset             = rst;
        bus.clear         = clr;
        bus.retain        = ret;
`ifdef REG_HISTORY_UNDO_EN
        bus.undo          = und;
`endif
        bus.valor_entrada = v;
        bus.rd_idx        = idx;
        if (rst || clr) begin
            mrd = '0;
            mq.delete();
        end else begin
            mrd = (int'(idx) < mq.size()) ? mq[idx] : '0;
            if (ret && und) begin
                if (mq.size() == 0) mq.push_front(v);
                else                mq[0] = v;
            end else if (ret) begin
                mq.push_front(v);
                if (mq.size() > DEPTH) void'(mq.pop_back());
            end else if (und) begin
                if (mq.size() > 0) void'(mq.pop_front());
            end
        end
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.clear  = 1'b0;
        bus.retain = 1'b0;
`ifdef REG_HISTORY_UNDO_EN
        bus.undo   = 1'b0;
`endif
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 2'd0);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h00, 3'd0, 1'b0, 8'h00};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL reset: got %h expected %h (salida|count|full|rd_valor)", got, exp_v);
        end else $display("[TB] reset ok: %h", got);
    endtask

    task automatic test_push_read();
        logic [1:0]   idx_tab [2] = '{2'd2, 2'd3};
        logic [N-1:0] rd_tab  [2] = '{8'h11, 8'h00};
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 2'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 2'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 2'd0);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h33, 3'd3, 1'b0, 8'h22};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL push3: got %h expected %h", got, exp_v);
        end else $display("[TB] push3 ok: %h", got);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, idx_tab[k]);
            got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
            exp_v = {8'h33, 3'd3, 1'b0, rd_tab[k]};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL read_idx%0d: got %h expected %h", idx_tab[k], got, exp_v);
            end else $display("[TB] read idx %0d ok: %h", idx_tab[k], got);
        end
    endtask

    task automatic test_push_full();
        logic [N-1:0] want [DEPTH] = '{8'h55, 8'h44, 8'h33, 8'h22};
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
        for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, N'(k * 8'h11), 2'd3);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h55, 3'd4, 1'b1, 8'h11};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL push5_full: got %h expected %h", got, exp_v);
        end else $display("[TB] push5 full ok: %h", got);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'(k));
            got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
            exp_v = {8'h55, 3'd4, 1'b1, want[k]};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL full_entry%0d: got %h expected %h", k, got, exp_v);
            end else $display("[TB] full entry %0d ok: %h", k, got);
        end
    endtask

`ifdef REG_HISTORY_UNDO_EN
    task automatic test_undo();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h33, 3'd2, 1'b0, 8'h44};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL undo2: got %h expected %h", got, exp_v);
        end else $display("[TB] undo x2 ok: %h", got);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h00, 3'd0, 1'b0, 8'h00};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL undo_underflow: got %h expected %h", got, exp_v);
        end else $display("[TB] undo to empty ok: %h", got);
    endtask

    task automatic test_replace();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 2'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 2'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 2'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'hAA, 3'd2, 1'b0, 8'h22};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL replace: got %h expected %h", got, exp_v);
        end else $display("[TB] replace ok: %h", got);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h5A, 3'd1, 1'b0, 8'h5A};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL replace_empty: got %h expected %h", got, exp_v);
        end else $display("[TB] replace at empty ok: %h", got);
    endtask
`endif

    task automatic test_clear_reset();
        for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, N'(8'hC0 + k), 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 2'd0);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h00, 3'd0, 1'b0, 8'h00};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL clear_retain: got %h expected %h", got, exp_v);
        end else $display("[TB] clear+retain ok: %h", got);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, N'(8'hD0 + k), 2'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 2'd0);
        got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
        exp_v = {8'h00, 3'd0, 1'b0, 8'h00};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_midpush: got %h expected %h", got, exp_v);
        end else $display("[TB] reset mid-push ok: %h", got);
    endtask

    task automatic test_random();
        logic rst, clr, ret, und;
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 31) == 0);
            ret = $urandom_range(0, 1) == 1;
`ifdef REG_HISTORY_UNDO_EN
            und = $urandom_range(0, 2) == 0;
`else
            und = 1'b0;
`endif
            cycle(rst, clr, ret, und, N'($urandom), 2'($urandom));
            got   = {bus.valor_salida, bus.count, bus.full, bus.rd_valor};
            exp_v = model_view();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL random[%0d] r%b c%b p%b u%b: got %h expected %h",
                         k, rst, clr, ret, und, got, exp_v);
            end
        end
        $display("[TB] random phase done");
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b1;
        bus.clear         = 1'b0;
        bus.retain        = 1'b0;
`ifdef REG_HISTORY_UNDO_EN
        bus.undo          = 1'b0;
`endif
        bus.valor_entrada = '0;
        bus.rd_idx        = '0;
        mrd               = '0;
        test_reset();
        test_push_read();
        test_push_full();
`ifdef REG_HISTORY_UNDO_EN
        test_undo();
        test_replace();
`endif
        test_clear_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
